// File: rtl/dds_pkg.sv
// Shared types and default widths for the DDS sweep sequencer and the DDS core.
package dds_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SWEEP = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DDS_M   = 24;
  localparam int DWELL_D = 16;

endpackage

// File: rtl/dds_dwell_cnt.sv
// Dwell counter: counts 0..limit while enabled and flags the terminal count.
module dds_dwell_cnt
  import dds_pkg::*;
#(
  parameter int D = DWELL_D
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [D-1:0] limit,
  output logic         tc
);

  logic [D-1:0] cnt_r;

  // Terminal count is only meaningful while the counter is running
  always_comb begin
    tc = en && (cnt_r == limit);
  end

  // Counter register, wraps to zero on the terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {D{1'b0}};
    end else if (clr) begin
      cnt_r <= {D{1'b0}};
    end else if (en) begin
      if (tc) begin
        cnt_r <= {D{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(D-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep sequencer driving all control inputs of the DDS core.
// Optional continuous mode: define DDS_SWEEP_LOOP_EN.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int M = DDS_M,
  parameter int D = DWELL_D
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [M-1:0] p_start,
  input  logic [M-1:0] p_stop,
  input  logic [M-1:0] p_step,
  input  logic [D-1:0] dwell,
  output logic [M-1:0] dds_p,
  output logic         dds_rst_ac,
  output logic         dds_ena_ac,
  output logic         dds_val_in,
  output logic         busy,
  output logic         done
);

  state_t       state_r;
  logic [M-1:0] p_start_r;
  logic [M-1:0] p_stop_r;
  logic [M-1:0] p_step_r;
  logic [D-1:0] dwell_r;
  logic [M-1:0] cur_p_r;
  logic [M:0]   sum_s;
  logic [M-1:0] next_p_s;
  logic         last_step_s;
  logic         cnt_en_s;
  logic         cnt_clr_s;
  logic         tc_s;
`ifdef DDS_SWEEP_LOOP_EN
  logic         restart_r;
`endif

  // Next increment, clamped at p_stop so it can neither overshoot nor wrap
  always_comb begin
    sum_s = {1'b0, cur_p_r} + {1'b0, p_step_r};
    if (sum_s > {1'b0, p_stop_r}) begin
      next_p_s = p_stop_r;
    end else begin
      next_p_s = sum_s[M-1:0];
    end
    last_step_s = (cur_p_r >= p_stop_r) || (p_step_r == {M{1'b0}});
    cnt_en_s    = (state_r == SWEEP) && !abort;
    cnt_clr_s   = !cnt_en_s;
  end

  dds_dwell_cnt #(.D(D)) u_dwell_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr_s),
    .en    (cnt_en_s),
    .limit (dwell_r),
    .tc    (tc_s)
  );

  // Sequencer FSM; outputs are registered from the current state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      p_start_r  <= {M{1'b0}};
      p_stop_r   <= {M{1'b0}};
      p_step_r   <= {M{1'b0}};
      dwell_r    <= {D{1'b0}};
      cur_p_r    <= {M{1'b0}};
      dds_p      <= {M{1'b0}};
      dds_rst_ac <= 1'b0;
      dds_ena_ac <= 1'b0;
      dds_val_in <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef DDS_SWEEP_LOOP_EN
      restart_r  <= 1'b0;
`endif
    end else if (abort && (state_r != IDLE)) begin
      state_r    <= IDLE;
      dds_p      <= {M{1'b0}};
      dds_rst_ac <= 1'b0;
      dds_ena_ac <= 1'b0;
      dds_val_in <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef DDS_SWEEP_LOOP_EN
      restart_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          dds_p      <= {M{1'b0}};
          dds_rst_ac <= 1'b0;
          dds_ena_ac <= 1'b0;
          dds_val_in <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          if (start) begin
            p_start_r <= p_start;
            p_stop_r  <= p_stop;
            p_step_r  <= p_step;
            dwell_r   <= dwell;
            state_r   <= START;
          end
        end
        START: begin
          cur_p_r    <= p_start_r;
          dds_p      <= p_start_r;
          dds_rst_ac <= 1'b1;
          dds_ena_ac <= 1'b0;
          dds_val_in <= 1'b0;
          busy       <= 1'b1;
`ifdef DDS_SWEEP_LOOP_EN
          done       <= restart_r;
          restart_r  <= 1'b0;
`else
          done       <= 1'b0;
`endif
          state_r    <= SWEEP;
        end
        SWEEP: begin
          dds_p      <= cur_p_r;
          dds_rst_ac <= 1'b0;
          dds_ena_ac <= 1'b1;
          dds_val_in <= 1'b1;
          busy       <= 1'b1;
          done       <= 1'b0;
          if (tc_s) begin
            if (last_step_s) begin
`ifdef DDS_SWEEP_LOOP_EN
              restart_r <= 1'b1;
              state_r   <= START;
`else
              state_r   <= DONE;
`endif
            end else begin
              cur_p_r <= next_p_s;
            end
          end
        end
        DONE: begin
          dds_p      <= cur_p_r;
          dds_rst_ac <= 1'b0;
          dds_ena_ac <= 1'b0;
          dds_val_in <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b1;
          state_r    <= IDLE;
        end
        default: begin
          state_r    <= IDLE;
          dds_p      <= {M{1'b0}};
          dds_rst_ac <= 1'b0;
          dds_ena_ac <= 1'b0;
          dds_val_in <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl; covers continuous mode when DDS_SWEEP_LOOP_EN is defined.
module tb_dds_sweep_ctrl;

  typedef struct packed {
    logic [23:0] p;
    logic        rst;
    logic        ena;
    logic        val;
    logic        busy;
    logic        done;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [23:0] p_start = 24'd0;
  logic [23:0] p_stop = 24'd0;
  logic [23:0] p_step = 24'd0;
  logic [15:0] dwell = 16'd0;
  logic [23:0] dds_p;
  logic        dds_rst_ac, dds_ena_ac, dds_val_in, busy, done;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   ena_seen = 0;

`ifdef DDS_SWEEP_LOOP_EN
  localparam int PASSES = 3;
`else
  localparam int PASSES = 1;
`endif

  dds_sweep_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .p_start    (p_start),
    .p_stop     (p_stop),
    .p_step     (p_step),
    .dwell      (dwell),
    .dds_p      (dds_p),
    .dds_rst_ac (dds_rst_ac),
    .dds_ena_ac (dds_ena_ac),
    .dds_val_in (dds_val_in),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [23:0] p, input logic r, input logic e,
                              input logic v, input logic b, input logic d);
    exp_t x;
    x.p = p; x.rst = r; x.ena = e; x.val = v; x.busy = b; x.done = d;
    return x;
  endfunction

  task automatic cycle_check(input string tag);
    exp_t e;
    exp_t got;
    @(posedge clk); #1;
    got = {dds_p, dds_rst_ac, dds_ena_ac, dds_val_in, busy, done};
    if (got.ena) ena_seen++;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: no expected entry, got p=%h", tag, got.p);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        failures++;
        $display("FAIL %s: got p=%h rst=%b ena=%b val=%b busy=%b done=%b, expected p=%h rst=%b ena=%b val=%b busy=%b done=%b",
                 tag, got.p, got.rst, got.ena, got.val, got.busy, got.done,
                 e.p, e.rst, e.ena, e.val, e.busy, e.done);
      end
    end
  endtask

  // Expected SWEEP cycles for one pass, from the linear-step-with-clamp rule
  task automatic push_pass(input logic [23:0] ps, input logic [23:0] pe,
                           input logic [23:0] st, input logic [15:0] dw,
                           output logic [23:0] last);
    logic [24:0] sum;
    logic [23:0] p;
    p = ps;
    for (int n = 0; n < 64; n++) begin
      for (int c = 0; c <= int'(dw); c++) exp_q.push_back(mk(p, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
      if (p >= pe || st == 24'd0) break;
      sum = {1'b0, p} + {1'b0, st};
      p = (sum > {1'b0, pe}) ? pe : sum[23:0];
    end
    last = p;
  endtask

  task automatic run_sweep(input string tag, input logic [23:0] ps, input logic [23:0] pe,
                           input logic [23:0] st, input logic [15:0] dw,
                           input logic with_abort, input int ena_per_pass);
    logic [23:0] lp;
    exp_q.delete();
    ena_seen = 0;
    p_start = ps; p_stop = pe; p_step = st; dwell = dw;
    start = 1'b1; abort = with_abort;
    exp_q.push_back(mk(24'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(ps, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    push_pass(ps, pe, st, dw, lp);
`ifdef DDS_SWEEP_LOOP_EN
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(mk(ps, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
      push_pass(ps, pe, st, dw, lp);
    end
    exp_q.push_back(mk(24'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
`else
    exp_q.push_back(mk(lp, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(mk(24'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
`endif
    cycle_check(tag);
    start = 1'b0; abort = 1'b0;
    p_start = 24'h5A5A5A; p_stop = 24'h000001; p_step = 24'h000003; dwell = 16'd7;
    for (int g = 0; g < 400 && exp_q.size() > 0; g++) begin
`ifdef DDS_SWEEP_LOOP_EN
      if (exp_q.size() == 1) abort = 1'b1;
`endif
      cycle_check(tag);
    end
    abort = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: %0d expected entries left, required 0", tag, exp_q.size());
    end
    checks++;
    if (ena_seen != ena_per_pass * PASSES) begin
      failures++;
      $display("FAIL %s_ena_cycles: got %0d, expected %0d", tag, ena_seen, ena_per_pass * PASSES);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({dds_p, dds_rst_ac, dds_ena_ac, dds_val_in, busy, done} !== 29'd0) begin
      failures++;
      $display("FAIL reset: got p=%h ctl=%b, expected all 0", dds_p,
               {dds_rst_ac, dds_ena_ac, dds_val_in, busy, done});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_sweep();
    logic [23:0] lp;
    exp_q.delete();
    p_start = 24'd100; p_stop = 24'd400; p_step = 24'd100; dwell = 16'd2;
    start = 1'b1;
    exp_q.push_back(mk(24'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(24'd100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    push_pass(24'd100, 24'd400, 24'd100, 16'd2, lp);
    cycle_check("rst_mid");
    start = 1'b0;
    for (int i = 0; i < 5; i++) cycle_check("rst_mid");
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({dds_p, dds_rst_ac, dds_ena_ac, dds_val_in, busy, done} !== 29'd0) begin
      failures++;
      $display("FAIL rst_async: got p=%h ctl=%b, expected all 0", dds_p,
               {dds_rst_ac, dds_ena_ac, dds_val_in, busy, done});
    end
    exp_q.delete();
    @(posedge clk); #3 rst_n = 1'b1;
    exp_q.push_back(mk(24'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cycle_check("rst_release");
  endtask

  task automatic test_abort();
    exp_q.delete();
    p_start = 24'd100; p_stop = 24'd400; p_step = 24'd100; dwell = 16'd2;
    start = 1'b1;
    exp_q.push_back(mk(24'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(24'd100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(24'd100, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(mk(24'd200, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(24'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cycle_check("abort");
    start = 1'b0;
    cycle_check("abort");
    // A start mid-sweep with a different config must not be latched
    start = 1'b1; p_start = 24'd7; p_stop = 24'd7; p_step = 24'd50; dwell = 16'd0;
    cycle_check("abort_restart_ignored");
    start = 1'b0;
    for (int i = 0; i < 3; i++) cycle_check("abort_restart_ignored");
    abort = 1'b1;
    cycle_check("abort_zero");
    abort = 1'b0;
    cycle_check("abort_no_done");
    cycle_check("abort_no_done");
  endtask

  initial begin
    test_reset();
    test_reset_mid_sweep();
    run_sweep("basic", 24'd100, 24'd400, 24'd100, 16'd2, 1'b0, 12);
    run_sweep("clamp_dwell0", 24'd0, 24'd250, 24'd100, 16'd0, 1'b1, 4);
    run_sweep("no_wrap", 24'hFFFF00, 24'hFFFFFF, 24'h000080, 16'd0, 1'b0, 3);
    run_sweep("start_ge_stop", 24'd500, 24'd300, 24'd10, 16'd1, 1'b0, 2);
    run_sweep("zero_step", 24'd20, 24'd90, 24'd0, 16'd3, 1'b0, 4);
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
